cmd_feeder: RTL and testbench

//  Input-side partner of the calculator controller: queues key commands from the keypad

---
 rtl/cmd_feeder_pkg.sv | 28 ++
 rtl/cmd_fifo.sv | 48 ++++
 rtl/cmd_feeder.sv | 133 +++++++++++++
 tb/tb_cmd_feeder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_feeder_pkg.sv
// Shared encodings for the calculator input-side feeder:
// controller command/response codes and feeder FSM states.
package cmd_feeder_pkg;

    localparam int IC_N = 4;
    localparam int OC_N = 2;
    localparam int OD_N = 16;

    localparam logic [IC_N-1:0] IC_NON = '0;

    typedef enum logic [OC_N-1:0] {
        OC_NON = 2'd0,
        OC_ACK = 2'd1,
        OC_NUM = 2'd2,
        OC_ERR = 2'd3
    } oc_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    function automatic logic is_resp(input logic [OC_N-1:0] oc);
        return oc != OC_NON;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small key-command FIFO: registered storage, combinational head,
// extra pointer bit distinguishes full from empty.
module cmd_fifo
    import cmd_feeder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = IC_N
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (wp_q[AW-1] != rp_q[AW-1]) &&
                     (wp_q[AW-2:0] == rp_q[AW-2:0]);
    assign empty   = (wp_q == rp_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rp_q[AW-2:0]];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + AW'(1);
            if (do_pop)  rp_q <= rp_q + AW'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) mem[wp_q[AW-2:0]] <= wdata;
    end

endmodule

// File: rtl/cmd_feeder.sv
// Queues keypad commands and offers them to the calculator controller,
// tracking its responses for the display.
module cmd_feeder
    import cmd_feeder_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            key_valid,
    input  logic [IC_N-1:0] key_cmd,
    output logic            key_ready,
    output logic [IC_N-1:0] in_cmd,
    input  logic            in_ack,
    input  logic [OC_N-1:0] out_cmd,
    input  logic [OD_N-1:0] out_data,
    output logic [OD_N-1:0] disp_data,
    output logic            disp_err,
    output logic            overflow,
    output logic            rejected,
    output logic            timeout
);

    localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

    state_e          state_q;
    state_e          state_d;
    logic [15:0]     cnt_q;
    logic [15:0]     cnt_d;
    logic            seen_q;
    logic            seen_d;
    logic            rej_d;
    logic            to_d;
    logic            pop;
    logic            clr_err;
    logic            resp;
    logic            push;
    logic            drop;
    logic            full;
    logic            empty;
    logic [IC_N-1:0] head;

    assign key_ready = !full;
    assign push      = key_valid && key_ready && (key_cmd != IC_NON);
    assign drop      = key_valid && !key_ready && (key_cmd != IC_NON);
    assign resp      = is_resp(out_cmd);

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (IC_N)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (push),
        .wdata (key_cmd),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Offer straight from registered state so in_cmd never sees in_ack.
    assign in_cmd = (state_q == ST_OFFER) ? head : IC_NON;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        rej_d   = 1'b0;
        to_d    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) state_d = ST_OFFER;
            end
            ST_OFFER: begin
                if (in_ack) begin
                    pop     = 1'b1;
                    clr_err = 1'b1;
                    seen_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                seen_d = seen_q | resp;
                if (in_ack) begin
                    state_d = ST_IDLE;
                    rej_d   = !(seen_q | resp);
                end else if (cnt_q == TMAX) begin
                    state_d = ST_IDLE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            rejected <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            rejected <= rej_d;
            timeout  <= to_d;
        end
    end

    // An error reported in the retire cycle belongs to the new command.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            disp_data <= '0;
            disp_err  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (clr_err) disp_err <= 1'b0;
            if (out_cmd == OC_ERR) disp_err <= 1'b1;
            if (out_cmd == OC_NUM) disp_data <= out_data;
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmd_feeder.sv
// Directed bench for cmd_feeder with a queue-based reference model
// compared every cycle, plus literal spot checks.
module tb_cmd_feeder;
    import cmd_feeder_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_cmd = '0;
    logic        key_ready;
    logic [3:0]  in_cmd;
    logic        in_ack = 1'b0;
    logic [1:0]  out_cmd = '0;
    logic [15:0] out_data = '0;
    logic [15:0] disp_data;
    logic        disp_err;
    logic        overflow;
    logic        rejected;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    cmd_feeder #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .key_valid (key_valid),
        .key_cmd   (key_cmd),
        .key_ready (key_ready),
        .in_cmd    (in_cmd),
        .in_ack    (in_ack),
        .out_cmd   (out_cmd),
        .out_data  (out_data),
        .disp_data (disp_data),
        .disp_err  (disp_err),
        .overflow  (overflow),
        .rejected  (rejected),
        .timeout   (timeout)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending keys and a transaction phase
    // (0 idle, 1 offering, 2 waiting for the controller).
    logic [3:0]  m_q[$];
    int          m_ph   = 0;
    int          m_cnt  = 0;
    bit          m_seen = 0;
    logic [15:0] m_data = '0;
    bit          m_err  = 0;
    bit          m_ovf  = 0;
    bit          m_rej  = 0;
    bit          m_to   = 0;

    task automatic model_step();
        int  n;
        bit  rsp;
        bit  pushk;
        logic [3:0] k;
        if (!Reset) begin
            m_q.delete();
            m_ph = 0; m_cnt = 0; m_seen = 0; m_data = '0;
            m_err = 0; m_ovf = 0; m_rej = 0; m_to = 0;
            return;
        end
        n     = m_q.size();
        rsp   = (out_cmd != 2'd0);
        pushk = key_valid && (n < DEPTH) && (key_cmd != 4'd0);
        m_rej = 0;
        m_to  = 0;
        if (key_valid && n >= DEPTH && key_cmd != 4'd0) m_ovf = 1;
        case (m_ph)
            0: if (n > 0) m_ph = 1;
            1: if (in_ack) begin
                k = m_q.pop_front();
                m_ph = 2; m_cnt = 0; m_seen = 0; m_err = 0;
            end
            default: begin
                if (in_ack) begin
                    m_ph = 0;
                    m_rej = !(m_seen || rsp);
                end else if (m_cnt == TIMEOUT - 1) begin
                    m_ph = 0;
                    m_to = 1;
                end else begin
                    m_cnt++;
                end
                m_seen = m_seen || rsp;
            end
        endcase
        if (out_cmd == 2'd3) m_err = 1;
        if (out_cmd == 2'd2) m_data = out_data;
        if (pushk) m_q.push_back(key_cmd);
    endtask

    initial forever begin
        @(posedge Clock or negedge Reset);
        model_step();
    end

    initial forever begin
        @(posedge Clock);
        #1;
        check("in_cmd", 32'(in_cmd),
              (m_ph == 1) ? 32'(m_q[0]) : 32'd0);
        check("key_ready", 32'(key_ready), 32'(m_q.size() < DEPTH));
        check("disp_data", 32'(disp_data), 32'(m_data));
        check("disp_err", 32'(disp_err), 32'(m_err));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("rejected", 32'(rejected), 32'(m_rej));
        check("timeout", 32'(timeout), 32'(m_to));
    end

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic send_key(input logic [3:0] k);
        key_valid = 1'b1;
        key_cmd   = k;
        tick();
        key_valid = 1'b0;
        key_cmd   = '0;
    endtask

    task automatic wait_offer(input string name);
        for (int i = 0; i < 20; i++) begin
            if (in_cmd != 4'd0) return;
            tick();
        end
        check({name, "_offer_timeout"}, 32'(in_cmd), 32'hF);
    endtask

    task automatic ack_cycle();
        in_ack = 1'b1;
        tick();
        in_ack = 1'b0;
    endtask

    task automatic resp_cycle(input logic [1:0] oc, input logic [15:0] d);
        out_cmd  = oc;
        out_data = d;
        tick();
        out_cmd  = '0;
        out_data = '0;
    endtask

    logic [3:0] got;

    initial begin
        #1 Reset = 1'b0;
        repeat (3) tick();
        check("rst_in_cmd", 32'(in_cmd), 32'd0);
        check("rst_key_ready", 32'(key_ready), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        Reset = 1'b1;
        tick();

        // Single key with ACK.
        send_key(4'h3);
        check("t1_not_yet", 32'(in_cmd), 32'd0);
        tick();
        check("t1_offer", 32'(in_cmd), 32'h3);
        ack_cycle();
        check("t1_after_ack", 32'(in_cmd), 32'd0);
        resp_cycle(2'd1, 16'h0);
        ack_cycle();
        check("t1_rejected", 32'(rejected), 32'd0);
        check("t1_timeout", 32'(timeout), 32'd0);

        // Number latch held across an ACK-only transaction.
        send_key(4'h5);
        wait_offer("t2a");
        ack_cycle();
        resp_cycle(2'd2, 16'h0123);
        check("t2_num", 32'(disp_data), 32'h0123);
        ack_cycle();
        send_key(4'h6);
        wait_offer("t2b");
        ack_cycle();
        resp_cycle(2'd1, 16'hFFFF);
        ack_cycle();
        check("t2_held", 32'(disp_data), 32'h0123);

        // Overflow: fifth key dropped, four drained in order.
        for (int i = 1; i <= 4; i++) send_key(4'(i));
        check("t3_full", 32'(key_ready), 32'd0);
        send_key(4'h5);
        check("t3_overflow", 32'(overflow), 32'd1);
        for (int j = 0; j < 4; j++) begin
            wait_offer("t3_drain");
            got = in_cmd;
            check("t3_order", 32'(got), 32'(j + 1));
            ack_cycle();
            resp_cycle(2'd1, 16'h0);
            ack_cycle();
        end
        repeat (4) begin
            tick();
            check("t3_empty", 32'(in_cmd), 32'd0);
        end

        // Error latch, then a reject that clears it.
        send_key(4'h7);
        wait_offer("t4a");
        ack_cycle();
        resp_cycle(2'd3, 16'h0);
        check("t4_err", 32'(disp_err), 32'd1);
        ack_cycle();
        send_key(4'h8);
        wait_offer("t4b");
        check("t4_err_held", 32'(disp_err), 32'd1);
        ack_cycle();
        check("t4_err_clr", 32'(disp_err), 32'd0);
        ack_cycle();
        check("t4_rej", 32'(rejected), 32'd1);
        tick();
        check("t4_rej_pulse", 32'(rejected), 32'd0);

        // Timeout after 8 WAIT cycles; in_ack on the last one wins.
        send_key(4'h9);
        wait_offer("t5a");
        ack_cycle();
        repeat (7) tick();
        check("t5_not_yet", 32'(timeout), 32'd0);
        tick();
        check("t5_timeout", 32'(timeout), 32'd1);
        check("t5_idle", 32'(in_cmd), 32'd0);
        tick();
        check("t5_to_pulse", 32'(timeout), 32'd0);
        send_key(4'hA);
        wait_offer("t5b");
        ack_cycle();
        repeat (7) tick();
        ack_cycle();
        check("t5_prio_rej", 32'(rejected), 32'd1);
        check("t5_prio_to", 32'(timeout), 32'd0);

        // Asynchronous reset mid-WAIT with two keys queued.
        send_key(4'hB);
        wait_offer("t6a");
        ack_cycle();
        resp_cycle(2'd2, 16'hBEEF);
        resp_cycle(2'd3, 16'h0);
        send_key(4'hC);
        send_key(4'hD);
        #2 Reset = 1'b0;
        #1;
        check("t6_in_cmd", 32'(in_cmd), 32'd0);
        check("t6_ready", 32'(key_ready), 32'd1);
        check("t6_ovf", 32'(overflow), 32'd0);
        check("t6_data", 32'(disp_data), 32'd0);
        check("t6_err", 32'(disp_err), 32'd0);
        tick();
        Reset = 1'b1;
        repeat (5) begin
            tick();
            check("t6_quiet", 32'(in_cmd), 32'd0);
        end
        send_key(4'hE);
        wait_offer("t6b");
        check("t6_new", 32'(in_cmd), 32'hE);
        ack_cycle();
        ack_cycle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
